// File: rtl/cpu_bus_write_ctrl.sv
// Registers the raw CPU bus and turns each sufficiently long write strobe into exactly one
// single-cycle bank write, a controller-register update, a write count and a short-strobe flag.
module cpu_bus_write_ctrl #(
  parameter int unsigned STABLE_CYCLES = 2,
  parameter logic [13:0] CTRL_ADDR     = 14'h0
) (
  input  logic        BUS_CLK,
  input  logic        RST_N,
  input  logic        EN,
  input  logic        WE,
  input  logic [1:0]  BRAM_SELECT,
  input  logic [13:0] BRAM_ADDR,
  input  logic [15:0] DATA_IN,
  output logic [3:0]  WR_EN,
  output logic [13:0] WR_ADDR,
  output logic [15:0] WR_DATA,
  output logic [14:0] CTRL_REG,
  output logic [15:0] WR_COUNT,
  output logic        ERR_SHORT
);

  typedef enum logic [1:0] {IDLE, COUNT, ISSUE, HOLD} state_t;

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);

  logic        en_q, we_q;
  logic [1:0]  sel_q;
  logic [13:0] addr_q;
  logic [15:0] data_q;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  wr_en_q;
  logic [13:0] wr_addr_q;
  logic [15:0] wr_data_q;
  logic [14:0] ctrl_q;
  logic [15:0] wr_count_q;
  logic        err_q;

  logic        act;
  logic        is_ctrl;
  logic [3:0]  bank_hit;

  always_ff @(posedge BUS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      en_q   <= 1'b0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      en_q   <= EN;
      we_q   <= WE;
      sel_q  <= BRAM_SELECT;
      addr_q <= BRAM_ADDR;
      data_q <= DATA_IN;
    end
  end

  assign act     = en_q & we_q;
  assign is_ctrl = (sel_q == 2'd0) && (addr_q == CTRL_ADDR);

  for (genvar gi = 0; gi < 4; gi++) begin : g_bank_dec
    assign bank_hit[gi] = (sel_q == 2'(gi));
  end

  // Outputs are registered on entry to ISSUE so they are visible for exactly that cycle.
  always_ff @(posedge BUS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_en_q    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      ctrl_q     <= '0;
      wr_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_en_q <= '0;
      case (state_q)
        IDLE: begin
          if (act) begin
            state_q <= COUNT;
            cnt_q   <= 4'd1;
          end
        end
        COUNT: begin
          if (!act) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end else if (cnt_q == CNT_MAX) begin
            state_q    <= ISSUE;
            wr_addr_q  <= addr_q;
            wr_data_q  <= data_q;
            wr_count_q <= wr_count_q + 16'd1;
            if (is_ctrl) begin
              ctrl_q <= data_q[14:0];
              if (data_q[15]) err_q <= 1'b0;
            end else begin
              wr_en_q <= bank_hit;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ISSUE: state_q <= HOLD;
        HOLD: begin
          // Only a release of the strobe re-arms the controller.
          if (!act) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign WR_EN     = wr_en_q;
  assign WR_ADDR   = wr_addr_q;
  assign WR_DATA   = wr_data_q;
  assign CTRL_REG  = ctrl_q;
  assign WR_COUNT  = wr_count_q;
  assign ERR_SHORT = err_q;

endmodule
